// File: rtl/toggle_event_decoder.sv
// ---------------------------------------------------------------------------
// toggle_event_decoder
//
// Receiving end of a toggle-encoded event line. Every level change on t_in is
// one event. Events are queued in a saturating pending counter, offered one at
// a time on a valid/ready handshake, and each accepted event is returned as a
// single toggle on ack_t.
//
// Configuration macro:
//   TOGGLE_DEC_SYNC_EN  defined   : two-flop synchronizer on t_in (async source),
//                                   event latency 3 edges.
//                       undefined : t_in used directly (must be synchronous to
//                                   clk), event latency 1 edge.
//
// Parameters:
//   CW         pending-counter width; queue depth is 2^CW-1 events.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   t_in       in   toggle-encoded event line
//   evt_ready  in   consumer ready; accept = evt_valid & evt_ready
//   evt_valid  out  at least one event pending (decoded from the counter)
//   ack_t      out  acknowledge toggle, flips once per accepted event
//   pending    out  number of queued events
//   overflow   out  sticky: an event was dropped while the queue was full
// ---------------------------------------------------------------------------
module toggle_event_decoder #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          t_in,
  input  logic          evt_ready,
  output logic          evt_valid,
  output logic          ack_t,
  output logic [CW-1:0] pending,
  output logic          overflow
);

  localparam logic [CW-1:0] PENDING_FULL = '1;

  // Synchronized view of t_in.
  logic s2;

`ifdef TOGGLE_DEC_SYNC_EN
  logic s1_q;
  logic s2_q;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its source (s2_q gets old s1_q).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= t_in;
      s2_q <= s1_q;
    end
  end

  assign s2 = s2_q;
`else
  assign s2 = t_in;
`endif

  // Reference level: previous synchronized value of the line. Resetting it to
  // 0 makes a line held high across reset release count as exactly one event.
  logic t_ref_q;

  logic          detect;
  logic          accept;
  logic [CW-1:0] pending_q;
  logic [CW-1:0] pending_d;
  logic          overflow_q;
  logic          overflow_d;
  logic          ack_q;
  logic          ack_d;

  assign detect    = s2 ^ t_ref_q;
  // evt_valid comes only from the registered counter, never from t_in.
  assign evt_valid = (pending_q != '0);
  assign accept    = evt_valid & evt_ready;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    ack_d      = ack_q ^ accept;

    if (detect && !accept) begin
      if (pending_q == PENDING_FULL) begin
        // Event lost: counter saturates, flag it.
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end else if (!detect && accept) begin
      pending_d = pending_q - 1'b1;
    end
    // detect && accept: one in, one out -- count unchanged even when full.
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_ref_q    <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      t_ref_q    <= s2;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      ack_q      <= ack_d;
    end
  end

  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign ack_t    = ack_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_toggle_event_decoder
//
// Self-checking bench for toggle_event_decoder (CW = 4). Works for both builds;
// the synchronizer depth follows TOGGLE_DEC_SYNC_EN. Expected behaviour comes
// from hand-written vectors and from an event-count model: the line history is
// kept as a list of sampled levels, an event is a difference between adjacent
// samples seen through the build's latency, and the queue is plain integer
// arithmetic clipped at 2^CW-1.
// ---------------------------------------------------------------------------
module tb_toggle_event_decoder;

  localparam int CW   = 4;
  localparam int MAXP = (1 << CW) - 1;
`ifdef TOGGLE_DEC_SYNC_EN
  localparam int D = 2;   // extra edges between sampling t_in and detection
`else
  localparam int D = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          t_in;
  logic          evt_ready;
  logic          evt_valid;
  logic          ack_t;
  logic [CW-1:0] pending;
  logic          overflow;

  toggle_event_decoder #(.CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .t_in      (t_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .ack_t     (ack_t),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit hist[$];
  int m_pend;
  bit m_ovf;
  bit m_ack;
  bit t_lvl;

  typedef struct {
    bit t;
    bit r;
    int exp_pend;
    bit exp_ack;
    bit exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= D; i++) hist.push_back(1'b0);
    m_pend = 0;
    m_ovf  = 1'b0;
    m_ack  = 1'b0;
  endtask

  task automatic model_edge(input bit t, input bit r);
    bit ev;
    bit acc;
    hist.push_back(t);
    ev  = hist[hist.size()-1-D] != hist[hist.size()-2-D];
    if (hist.size() > D + 2) void'(hist.pop_front());
    acc = (m_pend > 0) && r;
    if (acc) m_ack = !m_ack;
    m_pend = m_pend + int'(ev) - int'(acc);
    if (m_pend > MAXP) begin
      m_pend = MAXP;
      m_ovf  = 1'b1;
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, settle.
  task automatic step(input bit t, input bit r);
    t_in      = t;
    evt_ready = r;
    @(posedge clk);
    model_edge(t, r);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pending"},  32'(pending),   32'(m_pend));
    check({tag, "_valid"},    32'(evt_valid), 32'(m_pend != 0));
    check({tag, "_ack"},      32'(ack_t),     32'(m_ack));
    check({tag, "_overflow"}, 32'(overflow),  32'(m_ovf));
  endtask

  task automatic apply_reset(input bit t);
    t_in      = t;
    t_lvl     = t;
    evt_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Toggle the line, then hold it for D cycles so the event is counted.
  task automatic toggle_settle(input bit r_first);
    t_lvl = !t_lvl;
    step(t_lvl, r_first);
    repeat (D) step(t_lvl, 1'b0);
  endtask

  // Toggle so that the detect edge coincides with evt_ready=1.
  task automatic toggle_with_accept_on_detect();
    t_lvl = !t_lvl;
    step(t_lvl, D == 0);
    for (int k = 1; k <= D; k++) step(t_lvl, k == D);
  endtask

  vec_t vecs[8];

  initial begin
    int peak;
    int ack_flips;
    logic prev_ack;

    rst       = 1'b1;
    t_in      = 1'b0;
    evt_ready = 1'b0;
    t_lvl     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pending",  32'(pending),   32'd0);
    check("rst_valid",    32'(evt_valid), 32'd0);
    check("rst_ack",      32'(ack_t),     32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    rst = 1'b0;

    // Idle after reset: line low, nothing appears.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      check("idle_valid", 32'(evt_valid), 32'd0);
    end

    // Single event: exact latency, then one accept.
    step(1'b1, 1'b0);
    check("single_lat", 32'(pending), (D == 0) ? 32'd1 : 32'd0);
    for (int k = 1; k <= D; k++) begin
      step(1'b1, 1'b0);
      check("single_lat", 32'(pending), (k == D) ? 32'd1 : 32'd0);
    end
    check("single_valid", 32'(evt_valid), 32'd1);
    step(1'b1, 1'b1);
    check("single_drain", 32'(pending), 32'd0);
    check("single_ack",   32'(ack_t),   32'd1);

    // Table-driven vectors: each row is one driven cycle plus D settle cycles
    // with evt_ready low; expected values are the state after the row.
    vecs[0] = '{t: 1'b1, r: 1'b0, exp_pend: 1, exp_ack: 1'b0, exp_ovf: 1'b0};
    vecs[1] = '{t: 1'b0, r: 1'b0, exp_pend: 2, exp_ack: 1'b0, exp_ovf: 1'b0};
    vecs[2] = '{t: 1'b0, r: 1'b1, exp_pend: 1, exp_ack: 1'b1, exp_ovf: 1'b0};
    vecs[3] = '{t: 1'b1, r: 1'b1, exp_pend: 1, exp_ack: 1'b0, exp_ovf: 1'b0};
    vecs[4] = '{t: 1'b1, r: 1'b0, exp_pend: 1, exp_ack: 1'b0, exp_ovf: 1'b0};
    vecs[5] = '{t: 1'b1, r: 1'b1, exp_pend: 0, exp_ack: 1'b1, exp_ovf: 1'b0};
    vecs[6] = '{t: 1'b1, r: 1'b1, exp_pend: 0, exp_ack: 1'b1, exp_ovf: 1'b0};
    vecs[7] = '{t: 1'b0, r: 1'b0, exp_pend: 1, exp_ack: 1'b1, exp_ovf: 1'b0};
    apply_reset(1'b0);
    foreach (vecs[i]) begin
      step(vecs[i].t, vecs[i].r);
      repeat (D) step(vecs[i].t, 1'b0);
      check($sformatf("vec%0d_pending", i),  32'(pending),   32'(vecs[i].exp_pend));
      check($sformatf("vec%0d_valid", i),    32'(evt_valid), 32'(vecs[i].exp_pend != 0));
      check($sformatf("vec%0d_ack", i),      32'(ack_t),     32'(vecs[i].exp_ack));
      check($sformatf("vec%0d_overflow", i), 32'(overflow),  32'(vecs[i].exp_ovf));
    end

    // Burst of 5 back-to-back toggles, then drain one per cycle.
    apply_reset(1'b0);
    peak = 0;
    for (int i = 0; i < 5 + D; i++) begin
      if (i < 5) t_lvl = !t_lvl;
      step(t_lvl, 1'b0);
      check_model("burst");
      if (int'(pending) > peak) peak = int'(pending);
    end
    check("burst_peak", 32'(peak), 32'd5);
    ack_flips = 0;
    for (int i = 0; i < 5; i++) begin
      prev_ack = ack_t;
      step(t_lvl, 1'b1);
      check("drain_pending", 32'(pending), 32'(4 - i));
      if (ack_t !== prev_ack) ack_flips++;
    end
    check("drain_ack_flips", 32'(ack_flips), 32'd5);
    check("drain_ack_final", 32'(ack_t), 32'd1);

    // Simultaneous detect and accept at pending=2.
    apply_reset(1'b0);
    toggle_settle(1'b0);
    toggle_settle(1'b0);
    check("simul_pre", 32'(pending), 32'd2);
    toggle_with_accept_on_detect();
    check("simul_hold", 32'(pending), 32'd2);
    check("simul_ack",  32'(ack_t),   32'd1);
    step(t_lvl, 1'b1);
    check("simul_drain1", 32'(pending), 32'd1);
    step(t_lvl, 1'b1);
    check("simul_drain0", 32'(pending), 32'd0);

    // Saturation: fill to 15, detect+accept at full, then overflow.
    apply_reset(1'b0);
    for (int i = 0; i < 15; i++) begin
      t_lvl = !t_lvl;
      step(t_lvl, 1'b0);
    end
    repeat (D) step(t_lvl, 1'b0);
    check("full_pending",  32'(pending),  32'd15);
    check("full_overflow", 32'(overflow), 32'd0);
    toggle_with_accept_on_detect();
    check("full_simul_pending",  32'(pending),  32'd15);
    check("full_simul_overflow", 32'(overflow), 32'd0);
    toggle_settle(1'b0);
    check("sat_pending",  32'(pending),  32'd15);
    check("sat_overflow", 32'(overflow), 32'd1);
    check_model("sat");

    // Drain to 3 then reset asynchronously between edges.
    repeat (12) step(t_lvl, 1'b1);
    check("pre_rst_pending",  32'(pending),  32'd3);
    check("pre_rst_overflow", 32'(overflow), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pending",  32'(pending),   32'd0);
    check("async_rst_valid",    32'(evt_valid), 32'd0);
    check("async_rst_ack",      32'(ack_t),     32'd0);
    check("async_rst_overflow", 32'(overflow),  32'd0);

    // Line held high across reset release counts exactly one event.
    t_in  = 1'b1;
    t_lvl = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (D + 4) step(1'b1, 1'b0);
    check("high_release_pending", 32'(pending), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 45) t_lvl = !t_lvl;
      step(t_lvl, ($urandom_range(0, 99) < 40));
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
